// File: rtl/csr_wport_sched_if.sv
// Bundle of MEM/WB, trap-unit and csr_file write-port signals around the CSR write-port scheduler.
// The scheduler takes the slave view; the surrounding pipeline or a bench takes the master view.
interface csr_wport_sched_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) ();

    logic                      wb_csr_we_i;
    logic [CSR_ADDR_WIDTH-1:0] wb_csr_waddr_i;
    logic [DATA_WIDTH-1:0]     wb_csr_wdata_i;
    logic                      wb_retire_i;
    logic                      instret_inhibit_i;

    logic                      trap_req_i;
    logic [DATA_WIDTH-1:0]     trap_epc_i;
    logic [DATA_WIDTH-1:0]     trap_cause_i;
    logic [DATA_WIDTH-1:0]     trap_tval_i;
    logic [DATA_WIDTH-1:0]     trap_mstatus_i;

    logic                      stall_o;
    logic                      trap_busy_o;
    logic                      trap_done_o;
    logic                      csr_we_o;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o;
    logic [DATA_WIDTH-1:0]     csr_wdata_o;
    logic                      instret_incr_o;

    modport slave (
        input  wb_csr_we_i, wb_csr_waddr_i, wb_csr_wdata_i, wb_retire_i, instret_inhibit_i,
        input  trap_req_i, trap_epc_i, trap_cause_i, trap_tval_i, trap_mstatus_i,
        output stall_o, trap_busy_o, trap_done_o,
        output csr_we_o, csr_waddr_o, csr_wdata_o, instret_incr_o
    );

    modport master (
        output wb_csr_we_i, wb_csr_waddr_i, wb_csr_wdata_i, wb_retire_i, instret_inhibit_i,
        output trap_req_i, trap_epc_i, trap_cause_i, trap_tval_i, trap_mstatus_i,
        input  stall_o, trap_busy_o, trap_done_o,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, instret_incr_o
    );

endinterface

// File: rtl/csr_wport_sched.sv
// Owns the single csr_file write port: passes MEM/WB writes through when idle and
// serialises the four trap-entry writes (mepc, mcause, mtval, mstatus) while stalling the pipe.
module csr_wport_sched #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    csr_wport_sched_if.slave   bus
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDR_WIDTH'(12'h343);

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STATUS
    } state_e;

    state_e                    state_q, state_d;

    logic [DATA_WIDTH-1:0]     epc_q, epc_d;
    logic [DATA_WIDTH-1:0]     cause_q, cause_d;
    logic [DATA_WIDTH-1:0]     tval_q, tval_d;
    logic [DATA_WIDTH-1:0]     mstatus_q, mstatus_d;

    logic                      csr_we_q, csr_we_d;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q, csr_waddr_d;
    logic [DATA_WIDTH-1:0]     csr_wdata_q, csr_wdata_d;
    logic                      instret_incr_q, instret_incr_d;
    logic                      trap_done_q, trap_done_d;

    logic                      stall;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        tval_d         = tval_q;
        mstatus_d      = mstatus_q;
        csr_we_d       = 1'b0;
        csr_waddr_d    = bus.wb_csr_waddr_i;
        csr_wdata_d    = bus.wb_csr_wdata_i;
        instret_incr_d = 1'b0;
        trap_done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The pipeline op in the trap cycle is older than the trap, so it still issues.
                csr_we_d       = bus.wb_csr_we_i;
                instret_incr_d = bus.wb_retire_i & ~bus.instret_inhibit_i;
                if (bus.trap_req_i) begin
                    epc_d     = bus.trap_epc_i;
                    cause_d   = bus.trap_cause_i;
                    tval_d    = bus.trap_tval_i;
                    mstatus_d = bus.trap_mstatus_i;
                    state_d   = T_EPC;
                end
            end
            T_EPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MEPC;
                csr_wdata_d = epc_q;
                state_d     = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MCAUSE;
                csr_wdata_d = cause_q;
                state_d     = T_TVAL;
            end
            T_TVAL: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MTVAL;
                csr_wdata_d = tval_q;
                state_d     = T_STATUS;
            end
            T_STATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = ADDR_MSTATUS;
                csr_wdata_d = mstatus_q;
                trap_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q        <= IDLE;
            epc_q          <= '0;
            cause_q        <= '0;
            tval_q         <= '0;
            mstatus_q      <= '0;
            csr_we_q       <= 1'b0;
            csr_waddr_q    <= '0;
            csr_wdata_q    <= '0;
            instret_incr_q <= 1'b0;
            trap_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            tval_q         <= tval_d;
            mstatus_q      <= mstatus_d;
            csr_we_q       <= csr_we_d;
            csr_waddr_q    <= csr_waddr_d;
            csr_wdata_q    <= csr_wdata_d;
            instret_incr_q <= instret_incr_d;
            trap_done_q    <= trap_done_d;
        end
    end

    // Stall is combinational off the state so MEM/WB freezes in the same cycle the sequence starts.
    assign stall           = (state_q != IDLE);
    assign bus.stall_o     = stall;
    assign bus.trap_busy_o = stall;

    assign bus.trap_done_o    = trap_done_q;
    assign bus.csr_we_o       = csr_we_q;
    assign bus.csr_waddr_o    = csr_waddr_q;
    assign bus.csr_wdata_o    = csr_wdata_q;
    assign bus.instret_incr_o = instret_incr_q;

endmodule

// File: tb/tb_csr_wport_sched.sv
// Directed bench for csr_wport_sched: table of idle pass-through vectors plus
// hand-written trap, stall-hold, back-to-back and reset-abort sequences.
module tb_csr_wport_sched;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    csr_wport_sched_if #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

    csr_wport_sched #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        retire;
        logic        inhibit;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_incr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_wb(input logic we, input logic [11:0] addr, input logic [31:0] data,
                            input logic retire, input logic inhibit);
        bus.wb_csr_we_i       = we;
        bus.wb_csr_waddr_i    = addr;
        bus.wb_csr_wdata_i    = data;
        bus.wb_retire_i       = retire;
        bus.instret_inhibit_i = inhibit;
    endtask

    task automatic drive_trap(input logic req, input logic [31:0] epc, input logic [31:0] cause,
                              input logic [31:0] tval, input logic [31:0] mst);
        bus.trap_req_i     = req;
        bus.trap_epc_i     = epc;
        bus.trap_cause_i   = cause;
        bus.trap_tval_i    = tval;
        bus.trap_mstatus_i = mst;
    endtask

    // Full output check; addr/data only compared when a write is expected.
    task automatic check_out(input string name, input logic we, input logic [11:0] addr,
                             input logic [31:0] data, input logic incr, input logic done,
                             input logic stall);
        check({name, ".we"}, 32'(bus.csr_we_o), 32'(we));
        if (we) begin
            check({name, ".addr"}, 32'(bus.csr_waddr_o), 32'(addr));
            check({name, ".data"}, bus.csr_wdata_o, data);
        end
        check({name, ".incr"}, 32'(bus.instret_incr_o), 32'(incr));
        check({name, ".done"}, 32'(bus.trap_done_o), 32'(done));
        check({name, ".stall"}, 32'(bus.stall_o), 32'(stall));
        check({name, ".busy"}, 32'(bus.trap_busy_o), 32'(stall));
    endtask

    initial begin
        vecs[0] = '{"pt_write",    1'b1, 12'h305, 32'h8000_0100, 1'b0, 1'b0, 1'b1, 12'h305, 32'h8000_0100, 1'b0};
        vecs[1] = '{"pt_nowrite",  1'b0, 12'h123, 32'h0000_AAAA, 1'b0, 1'b0, 1'b0, 12'h123, 32'h0000_AAAA, 1'b0};
        vecs[2] = '{"retire",      1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0000_0000, 1'b1};
        vecs[3] = '{"retire_inh",  1'b0, 12'h000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 12'h000, 32'h0000_0000, 1'b0};
        vecs[4] = '{"write_ret",   1'b1, 12'h7FF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 12'h7FF, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"write_inh",   1'b1, 12'h001, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 12'h001, 32'h1234_5678, 1'b0};

        drive_wb(1'b1, 12'h305, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive_trap(1'b0, '0, '0, '0, '0);

        // Reset state: inputs active but reset held, everything must read zero.
        rst_i = 1'b0;
        tick();
        tick();
        check("rst.we",    32'(bus.csr_we_o), 32'd0);
        check("rst.addr",  32'(bus.csr_waddr_o), 32'd0);
        check("rst.data",  bus.csr_wdata_o, 32'd0);
        check("rst.incr",  32'(bus.instret_incr_o), 32'd0);
        check("rst.done",  32'(bus.trap_done_o), 32'd0);
        check("rst.stall", 32'(bus.stall_o), 32'd0);
        drive_wb(1'b0, '0, '0, 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();

        // Idle pass-through vectors.
        for (int i = 0; i < 6; i++) begin
            drive_wb(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].retire, vecs[i].inhibit);
            tick();
            check({vecs[i].name, ".we"},    32'(bus.csr_we_o), 32'(vecs[i].exp_we));
            check({vecs[i].name, ".addr"},  32'(bus.csr_waddr_o), 32'(vecs[i].exp_addr));
            check({vecs[i].name, ".data"},  bus.csr_wdata_o, vecs[i].exp_data);
            check({vecs[i].name, ".incr"},  32'(bus.instret_incr_o), 32'(vecs[i].exp_incr));
            check({vecs[i].name, ".done"},  32'(bus.trap_done_o), 32'd0);
            check({vecs[i].name, ".stall"}, 32'(bus.stall_o), 32'd0);
        end
        drive_wb(1'b0, '0, '0, 1'b0, 1'b0);
        tick();

        // Trap alone at N, then a back-to-back trap plus pipeline write at N+5.
        drive_trap(1'b1, 32'h100, 32'h2, 32'hDEAD_BEEF, 32'h1800);
        tick();
        drive_trap(1'b0, '0, '0, '0, '0);
        check_out("trap.n1", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("trap.epc", 1'b1, 12'h341, 32'h100, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("trap.cause", 1'b1, 12'h342, 32'h2, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("trap.tval", 1'b1, 12'h343, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("trap.mstatus", 1'b1, 12'h300, 32'h1800, 1'b0, 1'b1, 1'b0);
        drive_trap(1'b1, 32'h400, 32'h7, 32'h1234, 32'h1880);
        drive_wb(1'b1, 12'h305, 32'h1, 1'b0, 1'b0);
        tick();
        drive_trap(1'b0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0, 1'b0, 1'b0);
        check_out("b2b.pipe", 1'b1, 12'h305, 32'h1, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("b2b.epc", 1'b1, 12'h341, 32'h400, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("b2b.cause", 1'b1, 12'h342, 32'h7, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("b2b.tval", 1'b1, 12'h343, 32'h1234, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("b2b.mstatus", 1'b1, 12'h300, 32'h1880, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("b2b.idle", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Simultaneous trap + pipeline write, held write under stall, ignored second trap.
        drive_trap(1'b1, 32'h200, 32'hB, 32'h0, 32'h88);
        drive_wb(1'b1, 12'h340, 32'h55, 1'b1, 1'b0);
        tick();
        drive_trap(1'b0, '0, '0, '0, '0);
        drive_wb(1'b1, 12'h304, 32'h888, 1'b1, 1'b0);
        check_out("sim.pipe", 1'b1, 12'h340, 32'h55, 1'b1, 1'b0, 1'b1);
        tick();
        check_out("sim.epc", 1'b1, 12'h341, 32'h200, 1'b0, 1'b0, 1'b1);
        drive_trap(1'b1, 32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD);
        tick();
        drive_trap(1'b0, '0, '0, '0, '0);
        check_out("sim.cause", 1'b1, 12'h342, 32'hB, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("sim.tval", 1'b1, 12'h343, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("sim.mstatus", 1'b1, 12'h300, 32'h88, 1'b0, 1'b1, 1'b0);
        tick();
        drive_wb(1'b0, '0, '0, 1'b0, 1'b0);
        check_out("sim.held", 1'b1, 12'h304, 32'h888, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("sim.idle", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset mid-sequence at N+3 aborts the trap.
        drive_trap(1'b1, 32'h300, 32'h5, 32'hCAFE, 32'h8);
        tick();
        drive_trap(1'b0, '0, '0, '0, '0);
        check_out("abort.n1", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("abort.epc", 1'b1, 12'h341, 32'h300, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("abort.cause", 1'b1, 12'h342, 32'h5, 1'b0, 1'b0, 1'b1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("abort.rst.we",    32'(bus.csr_we_o), 32'd0);
        check("abort.rst.addr",  32'(bus.csr_waddr_o), 32'd0);
        check("abort.rst.data",  bus.csr_wdata_o, 32'd0);
        check("abort.rst.done",  32'(bus.trap_done_o), 32'd0);
        check("abort.rst.stall", 32'(bus.stall_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("abort.after%0d", i), 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
